// File: rtl/bp_cfg_boot_loader.sv
// rtl/bp_cfg_boot_loader.sv - boot sequencer issuing fixed config writes plus CCE microcode load
// Optional ucode readback/verify pass: define BP_CFG_BOOT_LOADER_READBACK_EN.
module bp_cfg_boot_loader #(
  parameter int          cfg_addr_width_p = 16,
  parameter int          cfg_data_width_p = 32,
  parameter int          ucode_entries_p  = 256,
  parameter int          num_lce_p        = 2,
  parameter int          cce_mode_p       = 0,
  parameter logic [31:0] npc_p            = 32'h8000_0000,
  localparam int         idx_width_lp     = (ucode_entries_p > 1) ? $clog2(ucode_entries_p) : 1
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          start_i,
  output logic                          ucode_v_o,
  output logic [idx_width_lp-1:0]       ucode_addr_o,
  input  logic [cfg_data_width_p-1:0]   ucode_data_i,
  output logic                          cfg_v_o,
  output logic                          cfg_w_o,
  output logic [cfg_addr_width_p-1:0]   cfg_addr_o,
  output logic [cfg_data_width_p-1:0]   cfg_data_o,
  input  logic                          cfg_ready_i,
  input  logic                          cfg_rdata_v_i,
  input  logic [cfg_data_width_p-1:0]   cfg_rdata_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          error_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_RST_ON, S_FRZ_ON, S_NUM_LCE, S_CCE_MODE,
    S_UC_FETCH, S_UC_SEND, S_UC_RB_FETCH, S_UC_RB_REQ, S_UC_RB_WAIT,
    S_NPC, S_RST_OFF, S_FRZ_OFF, S_DONE
  } state_e;

  localparam logic [cfg_addr_width_p-1:0] addr_reset_lp = cfg_addr_width_p'(32'h0001);
  localparam logic [cfg_addr_width_p-1:0] addr_freeze_lp = cfg_addr_width_p'(32'h0002);
  localparam logic [cfg_addr_width_p-1:0] addr_num_lce_lp = cfg_addr_width_p'(32'h0082);
  localparam logic [cfg_addr_width_p-1:0] addr_cce_mode_lp = cfg_addr_width_p'(32'h0081);
  localparam logic [cfg_addr_width_p-1:0] addr_npc_lp = cfg_addr_width_p'(32'h0040);

  state_e                        r_state;
  state_e                        w_state_next;
  logic [idx_width_lp-1:0]       r_idx;
  logic                          r_uc_fresh;
  logic [cfg_data_width_p-1:0]   r_uc_hold;
  logic                          w_hs;
  logic                          w_idx_last;
  logic                          w_idx_step;
  logic                          w_rb_resp;
  logic [31:0]                   w_uc_addr_full;
  logic [cfg_data_width_p-1:0]   w_uc_data;

  assign w_hs           = cfg_v_o & cfg_ready_i;
  assign w_idx_last     = (r_idx == idx_width_lp'(ucode_entries_p - 1));
  assign w_uc_addr_full = 32'h0000_8000 + 32'(r_idx);
  // ROM data is only valid the cycle after the strobe; later stall cycles replay the held copy
  assign w_uc_data      = r_uc_fresh ? ucode_data_i : r_uc_hold;
  assign w_idx_step     = ((r_state == S_UC_SEND) & w_hs) | w_rb_resp;

  assign ucode_addr_o = r_idx;
  assign busy_o       = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done_o       = (r_state == S_DONE);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) r_state <= S_IDLE;
    else            r_state <= w_state_next;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_idx      <= '0;
      r_uc_fresh <= 1'b0;
      r_uc_hold  <= '0;
    end else begin
      r_uc_fresh <= ucode_v_o;
      if (r_uc_fresh) r_uc_hold <= ucode_data_i;
      if (w_idx_step) r_idx <= w_idx_last ? '0 : r_idx + idx_width_lp'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (start_i) w_state_next = S_RST_ON;
      S_RST_ON:   if (w_hs) w_state_next = S_FRZ_ON;
      S_FRZ_ON:   if (w_hs) w_state_next = S_NUM_LCE;
      S_NUM_LCE:  if (w_hs) w_state_next = S_CCE_MODE;
      S_CCE_MODE: if (w_hs) w_state_next = S_UC_FETCH;
      S_UC_FETCH: w_state_next = S_UC_SEND;
`ifdef BP_CFG_BOOT_LOADER_READBACK_EN
      S_UC_SEND:     if (w_hs) w_state_next = w_idx_last ? S_UC_RB_FETCH : S_UC_FETCH;
      S_UC_RB_FETCH: w_state_next = S_UC_RB_REQ;
      S_UC_RB_REQ:   if (w_hs) w_state_next = S_UC_RB_WAIT;
      S_UC_RB_WAIT:  if (cfg_rdata_v_i) w_state_next = w_idx_last ? S_NPC : S_UC_RB_FETCH;
`else
      S_UC_SEND:     if (w_hs) w_state_next = w_idx_last ? S_NPC : S_UC_FETCH;
`endif
      S_NPC:      if (w_hs) w_state_next = S_RST_OFF;
      S_RST_OFF:  if (w_hs) w_state_next = S_FRZ_OFF;
      S_FRZ_OFF:  if (w_hs) w_state_next = S_DONE;
      S_DONE:     w_state_next = S_DONE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_v_o    = 1'b0;
    cfg_w_o    = 1'b0;
    cfg_addr_o = '0;
    cfg_data_o = '0;
    ucode_v_o  = 1'b0;
    case (r_state)
      S_RST_ON:   begin cfg_v_o = 1'b1; cfg_w_o = 1'b1; cfg_addr_o = addr_reset_lp;    cfg_data_o = cfg_data_width_p'(1); end
      S_FRZ_ON:   begin cfg_v_o = 1'b1; cfg_w_o = 1'b1; cfg_addr_o = addr_freeze_lp;   cfg_data_o = cfg_data_width_p'(1); end
      S_NUM_LCE:  begin cfg_v_o = 1'b1; cfg_w_o = 1'b1; cfg_addr_o = addr_num_lce_lp;  cfg_data_o = cfg_data_width_p'(num_lce_p); end
      S_CCE_MODE: begin cfg_v_o = 1'b1; cfg_w_o = 1'b1; cfg_addr_o = addr_cce_mode_lp; cfg_data_o = cfg_data_width_p'(cce_mode_p); end
      S_UC_FETCH, S_UC_RB_FETCH: ucode_v_o = 1'b1;
      S_UC_SEND:  begin cfg_v_o = 1'b1; cfg_w_o = 1'b1; cfg_addr_o = cfg_addr_width_p'(w_uc_addr_full); cfg_data_o = w_uc_data; end
      S_UC_RB_REQ: begin cfg_v_o = 1'b1; cfg_addr_o = cfg_addr_width_p'(w_uc_addr_full); end
      S_NPC:      begin cfg_v_o = 1'b1; cfg_w_o = 1'b1; cfg_addr_o = addr_npc_lp;      cfg_data_o = cfg_data_width_p'(npc_p); end
      S_RST_OFF:  begin cfg_v_o = 1'b1; cfg_w_o = 1'b1; cfg_addr_o = addr_reset_lp; end
      S_FRZ_OFF:  begin cfg_v_o = 1'b1; cfg_w_o = 1'b1; cfg_addr_o = addr_freeze_lp; end
      default: ;
    endcase
  end

`ifdef BP_CFG_BOOT_LOADER_READBACK_EN
  logic r_err;

  assign w_rb_resp = (r_state == S_UC_RB_WAIT) & cfg_rdata_v_i;
  assign error_o   = r_err;

  // r_uc_hold was refreshed during UC_RB_REQ, so it holds ROM[i] for the compare
  always_ff @(posedge clk_i) begin
    if (!reset_n_i)                                 r_err <= 1'b0;
    else if (w_rb_resp && (cfg_rdata_i != r_uc_hold)) r_err <= 1'b1;
  end
`else
  logic w_unused_rdata;

  assign w_rb_resp      = 1'b0;
  assign error_o        = 1'b0;
  assign w_unused_rdata = ^{cfg_rdata_v_i, cfg_rdata_i};
`endif

endmodule

// File: tb/tb_bp_cfg_boot_loader.sv
// tb/tb_bp_cfg_boot_loader.sv - randomized scoreboard bench for bp_cfg_boot_loader
module tb_bp_cfg_boot_loader;
  localparam int N = 4;

  typedef struct packed {
    logic        w;
    logic [15:0] addr;
    logic [31:0] data;
  } cmd_t;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        start_i;
  logic        ucode_v_o;
  logic [1:0]  ucode_addr_o;
  logic [31:0] ucode_data_i;
  logic        cfg_v_o, cfg_w_o;
  logic [15:0] cfg_addr_o;
  logic [31:0] cfg_data_o;
  logic        cfg_ready_i;
  logic        cfg_rdata_v_i;
  logic [31:0] cfg_rdata_i;
  logic        busy_o, done_o, error_o;

  cmd_t        exp_q[$];
  logic [31:0] rom[N];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          ready_pct = 100;
  bit          corrupt = 1'b0;
  bit          timing_exact = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bp_cfg_boot_loader #(.ucode_entries_p(N)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .start_i(start_i),
    .ucode_v_o(ucode_v_o), .ucode_addr_o(ucode_addr_o), .ucode_data_i(ucode_data_i),
    .cfg_v_o(cfg_v_o), .cfg_w_o(cfg_w_o), .cfg_addr_o(cfg_addr_o), .cfg_data_o(cfg_data_o),
    .cfg_ready_i(cfg_ready_i), .cfg_rdata_v_i(cfg_rdata_v_i), .cfg_rdata_i(cfg_rdata_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference boot log straight from the command list, not the state machine
  task automatic build_log();
    exp_q.push_back({1'b1, 16'h0001, 32'd1});
    exp_q.push_back({1'b1, 16'h0002, 32'd1});
    exp_q.push_back({1'b1, 16'h0082, 32'd2});
    exp_q.push_back({1'b1, 16'h0081, 32'd0});
    for (int i = 0; i < N; i++) exp_q.push_back({1'b1, 16'(16'h8000 + i), rom[i]});
`ifdef BP_CFG_BOOT_LOADER_READBACK_EN
    for (int i = 0; i < N; i++) exp_q.push_back({1'b0, 16'(16'h8000 + i), 32'd0});
`endif
    exp_q.push_back({1'b1, 16'h0040, 32'h8000_0000});
    exp_q.push_back({1'b1, 16'h0001, 32'd0});
    exp_q.push_back({1'b1, 16'h0002, 32'd0});
  endtask

  // Input driver: ROM with one-cycle latency, random backpressure, read responder
  initial begin
    logic        s_uv, s_rd, rd_pend;
    logic [1:0]  s_ua;
    logic [15:0] s_rda;
    logic [31:0] rd_val;
    int          rd_dly;
    rd_pend = 1'b0; rd_dly = 0; rd_val = 0;
    cfg_ready_i = 1'b1; ucode_data_i = '0; cfg_rdata_v_i = 1'b0; cfg_rdata_i = '0;
    forever begin
      @(negedge clk);
      s_uv  = ucode_v_o;
      s_ua  = ucode_addr_o;
      s_rd  = cfg_v_o && cfg_ready_i && !cfg_w_o && reset_n_i;
      s_rda = cfg_addr_o;
      @(posedge clk); #1;
      ucode_data_i  = s_uv ? rom[s_ua] : $urandom();
      cfg_ready_i   = ($urandom_range(0, 99) < ready_pct);
      cfg_rdata_v_i = 1'b0;
      cfg_rdata_i   = $urandom();
      if (!reset_n_i) rd_pend = 1'b0;
      if (s_rd) begin
        rd_pend = 1'b1;
        rd_dly  = $urandom_range(0, 2);
        rd_val  = (corrupt && s_rda == 16'h8001) ? 32'hFF : rom[s_rda - 16'h8000];
      end
      if (rd_pend) begin
        if (rd_dly == 0) begin
          cfg_rdata_v_i = 1'b1;
          cfg_rdata_i   = rd_val;
          rd_pend       = 1'b0;
        end else rd_dly--;
      end
    end
  end

  // Monitor: pops expected commands on each handshake and checks stall stability
  initial begin
    cmd_t        e;
    logic        stall_prev;
    logic [15:0] sa;
    logic [31:0] sd;
    logic        prev_done;
    int          first_v;
    stall_prev = 1'b0; prev_done = 1'b0; first_v = -1; sa = '0; sd = '0;
    forever begin
      @(negedge clk);
      if (!reset_n_i) begin
        exp_q.delete();
        stall_prev = 1'b0; prev_done = 1'b0; first_v = -1;
      end else begin
        if (stall_prev) begin
          check("stall_valid", cfg_v_o, 1'b1);
          check("stall_addr", cfg_addr_o, sa);
          check("stall_data", cfg_data_o, sd);
        end
        if (cfg_v_o && first_v < 0) first_v = cyc;
        if (cfg_v_o && cfg_ready_i) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_cmd: got addr %0h data %0h, no command expected", cfg_addr_o, cfg_data_o);
          end else begin
            e = exp_q.pop_front();
            check("cmd_w", cfg_w_o, e.w);
            check("cmd_addr", cfg_addr_o, e.addr);
            if (e.w) check("cmd_data", cfg_data_o, e.data);
          end
        end
        stall_prev = cfg_v_o && !cfg_ready_i;
        sa = cfg_addr_o;
        sd = cfg_data_o;
        if (done_o && !prev_done && timing_exact) check("done_cycles", cyc - first_v + 1, 8 + 2 * N);
        prev_done = done_o;
      end
    end
  end

  task automatic do_reset();
    start_i   = 1'b0;
    reset_n_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n_i = 1'b1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done_o && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    check("done_reached", done_o, 1'b1);
    @(negedge clk); #1;
    check("log_drained", exp_q.size(), 0);
    check("error_clear", error_o, corrupt);
  endtask

  initial begin
    bit found;
    for (int i = 0; i < N; i++) rom[i] = 32'hA0 + i;
    start_i   = 1'b0;
    reset_n_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cfg_v", cfg_v_o, 1'b0);
    check("rst_cfg_w", cfg_w_o, 1'b0);
    check("rst_cfg_addr", cfg_addr_o, 16'h0);
    check("rst_cfg_data", cfg_data_o, 32'h0);
    check("rst_ucode_v", ucode_v_o, 1'b0);
    check("rst_ucode_addr", ucode_addr_o, 2'd0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_error", error_o, 1'b0);
    reset_n_i = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      check("idle_cfg_v", cfg_v_o, 1'b0);
      check("idle_busy", busy_o, 1'b0);
      check("idle_done", done_o, 1'b0);
    end

`ifdef BP_CFG_BOOT_LOADER_READBACK_EN
    timing_exact = 1'b0;
`else
    timing_exact = 1'b1;
`endif
    build_log();
    pulse_start();
    check("busy_after_start", busy_o, 1'b1);
    wait_done();

    start_i = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      check("post_done_cfg_v", cfg_v_o, 1'b0);
      check("post_done_done", done_o, 1'b1);
    end
    start_i = 1'b0;

    do_reset();
    timing_exact = 1'b0;
    ready_pct = 30;
    build_log();
    pulse_start();
    wait_done();

    do_reset();
    ready_pct = 100;
    @(posedge clk); #1;
    build_log();
    pulse_start();
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (cfg_v_o && cfg_w_o && cfg_addr_o == 16'h8002) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("reached_uc2", found, 1'b1);
    reset_n_i = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", busy_o, 1'b0);
    check("midrst_cfg_v", cfg_v_o, 1'b0);
    @(posedge clk); #1;
    reset_n_i = 1'b1;
`ifndef BP_CFG_BOOT_LOADER_READBACK_EN
    timing_exact = 1'b1;
`endif
    build_log();
    pulse_start();
    wait_done();
    timing_exact = 1'b0;

`ifdef BP_CFG_BOOT_LOADER_READBACK_EN
    do_reset();
    corrupt = 1'b1;
    ready_pct = 70;
    build_log();
    pulse_start();
    wait_done();
    check("rb_error", error_o, 1'b1);
    check("rb_done", done_o, 1'b1);
`else
    check("no_rb_error", error_o, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
